param_spill_buffer: RTL

- Single-clock elastic buffer that cuts every combinational path between the upstream and downstream valid/ready handshakes.
- Generalises the two-entry spill register to a parametrised depth.
- Adds fill-level reporting, an almost-full flag, a synchronous flush and a transparent bypass mode.
- Sits between pipeline stages or interconnect ports where timing isolation and a small amount of elasticity are needed.

---
 rtl/param_spill_buffer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/param_spill_buffer.sv
// -----------------------------------------------------------------------------
// param_spill_buffer
// Single-clock elastic buffer with a parametrised number of entries. It breaks
// every combinational path between the upstream and downstream valid/ready
// handshakes. It also reports the fill level and an almost-full flag, and it
// supports a synchronous flush. When Bypass is set, the block is pure wires.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset (priority over flush_i)
//   flush_i        synchronous clear of all stored entries
//   valid_i/data_i upstream payload, accepted when ready_o is high
//   ready_o        buffer can accept a payload (decoded from state only)
//   valid_o/data_o downstream payload, taken from the oldest entry
//   ready_i        downstream accepts the payload
//   usage_o        number of stored entries
//   almost_full_o  usage_o >= AlmostFullTh
// -----------------------------------------------------------------------------
module param_spill_buffer #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned Depth        = 2,
    parameter int unsigned AlmostFullTh = Depth - 1,
    parameter bit          Bypass       = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [DataWidth-1:0]       data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DataWidth-1:0]       data_o,
    output logic [$clog2(Depth+1)-1:0] usage_o,
    output logic                       almost_full_o
);

    // A one-entry buffer still needs one index bit so the vectors stay legal.
    localparam int unsigned IdxW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned UsageW = $clog2(Depth + 1);

    if (Bypass) begin : g_bypass

        assign valid_o       = valid_i;
        assign ready_o       = ready_i;
        assign data_o        = data_i;
        assign usage_o       = '0;
        assign almost_full_o = 1'b0;

    end else begin : g_buffer

        if ((Depth < 1) || (Depth > 256)) begin : g_bad_depth
            $error("param_spill_buffer: Depth must be within 1..256");
        end
        if ((AlmostFullTh < 1) || (AlmostFullTh > Depth)) begin : g_bad_th
            $error("param_spill_buffer: AlmostFullTh must be within 1..Depth");
        end

        // Pointer layout: {phase, index}. The index wraps at Depth-1 rather
        // than at a power of two. The phase bit separates full from empty.
        function automatic logic [IdxW:0] ptr_inc(input logic [IdxW:0] ptr);
            logic [IdxW:0] nxt;
            if (ptr[IdxW-1:0] == IdxW'(Depth - 1)) begin
                nxt = {~ptr[IdxW], {IdxW{1'b0}}};
            end else begin
                nxt = {ptr[IdxW], ptr[IdxW-1:0] + IdxW'(1)};
            end
            return nxt;
        endfunction

        logic [DataWidth-1:0] r_mem [Depth];
        logic [IdxW:0]        r_wr_ptr;
        logic [IdxW:0]        r_rd_ptr;
        logic [UsageW-1:0]    r_usage;
        logic                 w_empty;
        logic                 w_full;
        logic                 w_push;
        logic                 w_pop;

        assign w_empty = (r_wr_ptr[IdxW-1:0] == r_rd_ptr[IdxW-1:0]) &&
                         (r_wr_ptr[IdxW] == r_rd_ptr[IdxW]);
        assign w_full  = (r_wr_ptr[IdxW-1:0] == r_rd_ptr[IdxW-1:0]) &&
                         (r_wr_ptr[IdxW] != r_rd_ptr[IdxW]);

        // Status comes from registered state only. A full buffer therefore
        // refuses a new payload even in the cycle where it releases one.
        assign ready_o       = ~w_full;
        assign valid_o       = ~w_empty;
        assign data_o        = r_mem[r_rd_ptr[IdxW-1:0]];
        assign usage_o       = r_usage;
        assign almost_full_o = (r_usage >= UsageW'(AlmostFullTh));

        // A flush drops any transfer presented in the same cycle.
        assign w_push = valid_i & ~w_full & ~flush_i;
        assign w_pop  = ready_i & ~w_empty & ~flush_i;

        // Pointer and phase update, cleared by reset or flush.
        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
            end
        end

        // Fill-level counter. It tracks the pointer distance but is kept as
        // its own register so usage_o comes straight from a flop.
        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                r_usage <= '0;
            end else if (w_push && !w_pop) begin
                r_usage <= r_usage + UsageW'(1);
            end else if (w_pop && !w_push) begin
                r_usage <= r_usage - UsageW'(1);
            end else begin
                r_usage <= r_usage;
            end
        end

        // Payload storage. It has no reset; the entry is written on each push.
        always_ff @(posedge clk_i) begin
            if (w_push && !rst_i) begin
                r_mem[r_wr_ptr[IdxW-1:0]] <= data_i;
            end
        end

    end

endmodule
